// File: rtl/flop_out_sram_fifo_pf.sv
// Single-clock FIFO: 1R1W SRAM with RD_LAT-cycle reads feeding a flop prefetch buffer,
// so rDat is always a flop and a word can be popped every cycle.
module flop_out_sram_fifo_pf #(
  parameter int DATA      = 64,
  parameter int DEPTH     = 512,
  parameter int RD_LAT    = 1,
  parameter int AF_THRESH = DEPTH - 8,
  localparam int PF_DEPTH = RD_LAT + 1,
  localparam int NUM_W    = $clog2(DEPTH + PF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             clear,
  input  logic             wDatValid,
  output logic             wDatReady,
  input  logic [DATA-1:0]  wDat,
  output logic             rDatValid,
  input  logic             rDatReady,
  output logic [DATA-1:0]  rDat,
  output logic [NUM_W-1:0] num,
  output logic             almostFull,
  output logic             errOvf,
  output logic             errUdf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PC_W  = $clog2(PF_DEPTH + 1) + 1;

  // pointer MSB is the wrap bit
  logic [PTR_W:0]    wp, rp;
  logic [PTR_W:0]    sram_cnt, sram_cnt_nxt;
  logic [DATA-1:0]   mem [DEPTH];
  logic [DATA-1:0]   pipe_dat [RD_LAT];
  logic [RD_LAT-1:0] pipe_vld;
  logic [PC_W-1:0]   inflight, inflight_nxt;
  logic [PC_W-1:0]   pf_cnt, pf_cnt_nxt, pf_slot, occ;
  logic [DATA-1:0]   pf_dat [PF_DEPTH];
  logic [DATA-1:0]   pf_dat_nxt [PF_DEPTH];
  logic [NUM_W-1:0]  num_nxt;
  logic              wack, rack, re, land;

  assign wack     = wDatValid & wDatReady;
  assign rack     = rDatValid & rDatReady;
  assign land     = pipe_vld[RD_LAT-1];
  assign sram_cnt = wp - rp;

  // counting this cycle's pop keeps the read pipeline full under sustained reads
  assign occ = inflight + pf_cnt - PC_W'(rack);
  assign re  = !clear && (sram_cnt != '0) && (occ < PC_W'(PF_DEPTH));

  assign sram_cnt_nxt = sram_cnt + (PTR_W+1)'(wack) - (PTR_W+1)'(re);
  assign inflight_nxt = inflight + PC_W'(re) - PC_W'(land);
  assign pf_cnt_nxt   = pf_cnt - PC_W'(rack) + PC_W'(land);
  assign pf_slot      = pf_cnt - PC_W'(rack);
  assign num_nxt      = clear ? '0 : num + NUM_W'(wack) - NUM_W'(rack);
  assign rDat         = pf_dat[0];

  always_comb begin
    for (int i = 0; i < PF_DEPTH; i++) pf_dat_nxt[i] = pf_dat[i];
    if (rack) begin
      for (int i = 0; i < PF_DEPTH - 1; i++) pf_dat_nxt[i] = pf_dat[i+1];
    end
    for (int i = 0; i < PF_DEPTH; i++) begin
      if (land && (PC_W'(i) == pf_slot)) pf_dat_nxt[i] = pipe_dat[RD_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (wack && !clear) mem[wp[PTR_W-1:0]] <= wDat;
  end

  always_ff @(posedge clk) begin
    if (re) pipe_dat[0] <= mem[rp[PTR_W-1:0]];
    for (int i = 1; i < RD_LAT; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wp         <= '0;
      rp         <= '0;
      inflight   <= '0;
      pf_cnt     <= '0;
      pipe_vld   <= '0;
      num        <= '0;
      wDatReady  <= 1'b1;
      rDatValid  <= 1'b0;
      almostFull <= 1'b0;
      errOvf     <= 1'b0;
      errUdf     <= 1'b0;
      for (int i = 0; i < PF_DEPTH; i++) pf_dat[i] <= '0;
    end else begin
      errOvf     <= errOvf | (wDatValid & ~wDatReady);
      errUdf     <= errUdf | (rDatReady & ~rDatValid);
      num        <= num_nxt;
      almostFull <= (num_nxt >= NUM_W'(AF_THRESH));
      for (int i = 0; i < PF_DEPTH; i++) pf_dat[i] <= pf_dat_nxt[i];
      if (clear) begin
        wp        <= '0;
        rp        <= '0;
        inflight  <= '0;
        pf_cnt    <= '0;
        pipe_vld  <= '0;
        wDatReady <= 1'b1;
        rDatValid <= 1'b0;
      end else begin
        if (wack) wp <= wp + (PTR_W+1)'(1);
        if (re)   rp <= rp + (PTR_W+1)'(1);
        inflight    <= inflight_nxt;
        pf_cnt      <= pf_cnt_nxt;
        pipe_vld[0] <= re;
        for (int i = 1; i < RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
        wDatReady <= (sram_cnt_nxt < (PTR_W+1)'(DEPTH));
        rDatValid <= (pf_cnt_nxt != '0);
      end
    end
  end

endmodule

// File: tb/tb_flop_out_sram_fifo_pf.sv
// Bench: three DEPTH=16 instances (RD_LAT 1..3) on shared stimulus, each tracked by a
// queue model that predicts contents, num, flags and when the head word becomes visible.
module tb_flop_out_sram_fifo_pf;
  localparam int DEP = 16;
  localparam int AF  = 8;
  localparam int NW  = 5;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, wvalid = 1'b0, rready = 1'b0;
  logic [63:0] wdat = '0;
  logic wready[3], rvalid[3], almost[3], ovf[3], udf[3];
  logic [63:0] rdat[3];
  logic [NW-1:0] num[3];
  int cyc;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = g + 1;
    localparam int CAP = DEP + LAT + 1;

    flop_out_sram_fifo_pf #(.DATA(64), .DEPTH(DEP), .RD_LAT(LAT), .AF_THRESH(AF)) u_dut (
      .clk(clk), .rstN(rst_n), .clear(clear),
      .wDatValid(wvalid), .wDatReady(wready[g]), .wDat(wdat),
      .rDatValid(rvalid[g]), .rDatReady(rready), .rDat(rdat[g]),
      .num(num[g]), .almostFull(almost[g]), .errOvf(ovf[g]), .errUdf(udf[g]));

    logic [63:0] mq[$];
    int          wq[$];
    int          pops;
    bit          movf, mudf, p_flush, p_w, p_r, p_ovf, p_udf, ev;
    logic [63:0] p_dat;
    int          p_cyc;

    // model updates land on the negedge after the posedge where the handshake happened
    initial begin
      pops = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          mq.delete(); wq.delete();
          movf = 0; mudf = 0; p_flush = 0; p_w = 0; p_r = 0; p_ovf = 0; p_udf = 0;
        end else begin
          movf |= p_ovf;
          mudf |= p_udf;
          if (p_flush) begin
            mq.delete(); wq.delete();
          end else begin
            if (p_r) begin void'(mq.pop_front()); void'(wq.pop_front()); pops++; end
            if (p_w) begin mq.push_back(p_dat); wq.push_back(p_cyc); end
          end
          ev = (mq.size() > 0) ? (cyc >= wq[0] + LAT + 2) : 1'b0;
          check($sformatf("d%0d num", g), 64'(num[g]), 64'(mq.size()));
          check($sformatf("d%0d almostFull", g), 64'(almost[g]), 64'(mq.size() >= AF));
          check($sformatf("d%0d rDatValid", g), 64'(rvalid[g]), 64'(ev));
          if (ev) check($sformatf("d%0d rDat", g), rdat[g], mq[0]);
          if (mq.size() < DEP) check($sformatf("d%0d wDatReady low early", g), 64'(wready[g]), 64'd1);
          if (mq.size() == CAP) check($sformatf("d%0d wDatReady at cap", g), 64'(wready[g]), 64'd0);
          check($sformatf("d%0d errOvf", g), 64'(ovf[g]), 64'(movf));
          check($sformatf("d%0d errUdf", g), 64'(udf[g]), 64'(mudf));
          p_flush = clear;
          p_w     = wvalid && wready[g] && !clear && (mq.size() < CAP);
          p_r     = ev && rready && !clear;
          p_dat   = wdat;
          p_cyc   = cyc;
          p_ovf   = wvalid && !wready[g];
          p_udf   = rready && !ev;
        end
      end
    end
  end

  int cap[3];
  bit seen[3];
  int base[3];
  int k;

  task automatic check_reset_outputs(string tag);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s d%0d wDatReady", tag, g), 64'(wready[g]), 64'd1);
      check($sformatf("%s d%0d rDatValid", tag, g), 64'(rvalid[g]), 64'd0);
      check($sformatf("%s d%0d num", tag, g), 64'(num[g]), 64'd0);
      check($sformatf("%s d%0d almostFull", tag, g), 64'(almost[g]), 64'd0);
      check($sformatf("%s d%0d errOvf", tag, g), 64'(ovf[g]), 64'd0);
      check($sformatf("%s d%0d errUdf", tag, g), 64'(udf[g]), 64'd0);
      check($sformatf("%s d%0d rDat", tag, g), rdat[g], 64'd0);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) cap[g] = DEP + g + 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // single word latency on RD_LAT=2
    while (cyc < 10) step();
    wvalid = 1'b1; wdat = 64'hA5; rready = 1'b1;
    step();
    wvalid = 1'b0;
    while (cyc < 13) step();
    @(negedge clk);
    check("lat c13 rDatValid", 64'(rvalid[1]), 64'd0);
    step(); @(negedge clk);
    check("lat c14 rDatValid", 64'(rvalid[1]), 64'd1);
    check("lat c14 rDat", rdat[1], 64'hA5);
    check("lat c14 num", 64'(num[1]), 64'd1);
    step(); @(negedge clk);
    check("lat c15 num", 64'(num[1]), 64'd0);

    // fill to capacity with reads stalled
    step();
    rready = 1'b0; wvalid = 1'b1;
    repeat (30) begin wdat = {$urandom, $urandom}; step(); end
    wvalid = 1'b0;
    step(); @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("fill d%0d num", g), 64'(num[g]), 64'(cap[g]));
      check($sformatf("fill d%0d wDatReady", g), 64'(wready[g]), 64'd0);
      check($sformatf("fill d%0d almostFull", g), 64'(almost[g]), 64'd1);
    end

    // sustained streaming from full: one pop-only cycle, then no bubbles on either side
    step();
    rready = 1'b1; wvalid = 1'b0;
    step();
    wvalid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wdat = 64'(i);
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        check($sformatf("stream d%0d wDatReady", g), 64'(wready[g]), 64'd1);
        check($sformatf("stream d%0d rDatValid", g), 64'(rvalid[g]), 64'd1);
        check($sformatf("stream d%0d num", g), 64'(num[g]), 64'(cap[g] - 1));
      end
      step();
    end

    // clear with reads in flight
    wvalid = 1'b0; rready = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0; wvalid = 1'b1;
    for (int i = 0; i < 12; i++) begin wdat = 64'h100 + 64'(i); step(); end
    wvalid = 1'b0; rready = 1'b1;
    repeat (3) step();
    clear = 1'b1; wvalid = 1'b1; wdat = 64'hDEAD;
    @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("preclear d%0d num", g), 64'(num[g]), 64'd9);
    step();
    clear = 1'b0; wvalid = 1'b0; rready = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("postclear d%0d num", g), 64'(num[g]), 64'd0);
      check($sformatf("postclear d%0d rDatValid", g), 64'(rvalid[g]), 64'd0);
      check($sformatf("postclear d%0d wDatReady", g), 64'(wready[g]), 64'd1);
    end
    step();
    wvalid = 1'b1; wdat = 64'h77;
    step();
    wdat = 64'h88;
    step();
    wvalid = 1'b0; rready = 1'b1;
    for (int g = 0; g < 3; g++) seen[g] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        if (!seen[g] && rvalid[g]) begin
          check($sformatf("postclear d%0d first word", g), rdat[g], 64'h77);
          seen[g] = 1'b1;
        end
      step();
    end
    for (int g = 0; g < 3; g++) check($sformatf("postclear d%0d word seen", g), 64'(seen[g]), 64'd1);

    // random traffic against the queue models
    base[0] = g_dut[0].pops; base[1] = g_dut[1].pops; base[2] = g_dut[2].pops;
    k = 0;
    while ((g_dut[0].pops < base[0] + 10000 || g_dut[1].pops < base[1] + 10000 ||
            g_dut[2].pops < base[2] + 10000) && k < 60000) begin
      wvalid = 1'($urandom_range(0, 1));
      rready = 1'($urandom_range(0, 1));
      wdat   = {$urandom, $urandom};
      step();
      k++;
    end
    wvalid = 1'b0; rready = 1'b0;
    check("random cycle budget", 64'(k < 60000), 64'd1);

    // async reset, then sticky error flags survive clear
    step();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    step();
    rst_n = 1'b1;
    rready = 1'b1;
    step();
    rready = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("udf d%0d errUdf", g), 64'(udf[g]), 64'd1);
      check($sformatf("udf d%0d num", g), 64'(num[g]), 64'd0);
    end
    step();
    wvalid = 1'b1;
    repeat (25) begin wdat = {$urandom, $urandom}; step(); end
    wvalid = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("ovf d%0d errOvf", g), 64'(ovf[g]), 64'd1);
      check($sformatf("ovf d%0d num", g), 64'(num[g]), 64'(cap[g]));
    end
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("sticky d%0d errOvf", g), 64'(ovf[g]), 64'd1);
      check($sformatf("sticky d%0d errUdf", g), 64'(udf[g]), 64'd1);
      check($sformatf("sticky d%0d num", g), 64'(num[g]), 64'd0);
    end
    step();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("final");
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
